// File: rtl/muldiv_seq_if.sv
// Request/response bundle for the sequential multiply/divide unit.
// The requester drives the master side; muldiv_seq sits on the slave side.
interface muldiv_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        busy;
  logic        out_valid;
  logic [31:0] result;

  modport master (
    output in_valid, op, src1, src2, flush,
    input  in_ready, busy, out_valid, result
  );

  modport slave (
    input  in_valid, op, src1, src2, flush,
    output in_ready, busy, out_valid, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative 32-bit multiply/divide: radix-2 shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with a sign-fix cycle before the result.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_cnt;
  logic [2:0]  r_op;
  logic [63:0] r_prod;
  logic [63:0] r_mcand;
  logic [31:0] r_b;
  logic [31:0] r_rem;
  logic [31:0] r_result;
  logic        r_neg;
  logic        r_rem_neg;

  logic        w_accept;
  logic        w_s1_signed;
  logic        w_s2_signed;
  logic        w_s1_neg;
  logic        w_s2_neg;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic        w_div0;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_special_result;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_final;

  assign bus.in_ready  = (r_state == IDLE) && !bus.flush && !rst;
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign w_accept      = bus.in_valid && bus.in_ready;

  // MULH, MULHSU, DIV and REM treat src1 as signed; MULH, DIV and REM also src2.
  assign w_s1_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
  assign w_s2_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
  assign w_s1_neg    = w_s1_signed && bus.src1[31];
  assign w_s2_neg    = w_s2_signed && bus.src2[31];
  assign w_mag1      = w_s1_neg ? (32'd0 - bus.src1) : bus.src1;
  assign w_mag2      = w_s2_neg ? (32'd0 - bus.src2) : bus.src2;

  assign w_div0    = bus.op[2] && (bus.src2 == 32'd0);
  assign w_ovf     = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                     (bus.src1 == 32'h8000_0000) && (bus.src2 == 32'hFFFF_FFFF);
  assign w_special = w_div0 || w_ovf;

  always_comb begin
    w_special_result = 32'd0;
    if (w_div0)
      w_special_result = bus.op[1] ? bus.src1 : 32'hFFFF_FFFF;
    else if (w_ovf)
      w_special_result = bus.op[1] ? 32'd0 : 32'h8000_0000;
  end

  // Restoring step: the divisor lives in r_mcand[31:0]; a borrow in bit 32 means "restore".
  assign w_shift = {r_rem, r_b[31]};
  assign w_diff  = w_shift - {1'b0, r_mcand[31:0]};

  assign w_prod_fix = r_neg ? (64'd0 - r_prod) : r_prod;
  assign w_quo_fix  = r_neg ? (32'd0 - r_b) : r_b;
  assign w_rem_fix  = r_rem_neg ? (32'd0 - r_rem) : r_rem;

  always_comb begin
    w_final = 32'd0;
    case (r_op)
      3'd0:          w_final = w_prod_fix[31:0];
      3'd1, 3'd2, 3'd3: w_final = w_prod_fix[63:32];
      3'd4, 3'd5:    w_final = w_quo_fix;
      default:       w_final = w_rem_fix;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_special ? DONE : CALC;
      CALC:    if (r_cnt == 6'd31) w_state_next = FIX;
      FIX:     w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (bus.flush) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 6'd0;
      r_op      <= 3'd0;
      r_prod    <= 64'd0;
      r_mcand   <= 64'd0;
      r_b       <= 32'd0;
      r_rem     <= 32'd0;
      r_result  <= 32'd0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_op      <= bus.op;
          r_cnt     <= 6'd0;
          r_prod    <= 64'd0;
          r_rem     <= 32'd0;
          r_mcand   <= {32'd0, bus.op[2] ? w_mag2 : w_mag1};
          r_b       <= bus.op[2] ? w_mag1 : w_mag2;
          r_neg     <= w_s1_neg ^ w_s2_neg;
          r_rem_neg <= w_s1_neg;
          if (w_special) r_result <= w_special_result;
        end
        CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (!r_op[2]) begin
            if (r_b[0]) r_prod <= r_prod + r_mcand;
            r_mcand <= {r_mcand[62:0], 1'b0};
            r_b     <= {1'b0, r_b[31:1]};
          end else begin
            r_rem <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
            r_b   <= {r_b[30:0], ~w_diff[32]};
          end
        end
        FIX: if (!bus.flush) begin
          r_prod   <= w_prod_fix;
          r_b      <= w_quo_fix;
          r_rem    <= w_rem_fix;
          r_result <= w_final;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, results, special cases, flush and reset.
module tb_muldiv_seq;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts in the cycle after accept; measures cycles to out_valid and checks the aftermath.
  task automatic wait_done(input int exp_lat, input logic [31:0] exp_res, input string tag);
    int lat;
    int busy_n;
    logic [31:0] res;
    lat = 0;
    busy_n = 0;
    res = '0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      if (bus.busy) busy_n++;
      if (bus.out_valid) begin
        lat = k;
        res = bus.result;
      end else begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, {32'd0, res}, {32'd0, exp_res});
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
    @(posedge clk); #1;
    check({tag, "_ov_one_cycle"}, {63'd0, bus.out_valid}, 64'd0);
    check({tag, "_idle_after"}, {63'd0, bus.busy}, 64'd0);
    check({tag, "_res_held"}, {32'd0, bus.result}, {32'd0, exp_res});
    $display("[TB] %s op done: latency %0d result %h", tag, lat, res);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.src1 = a;
    bus.src2 = b;
    #1;
    check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom);
    bus.src1 = $urandom;
    bus.src2 = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res, input string tag);
    issue(op, a, b, tag);
    wait_done(exp_lat, exp_res, tag);
  endtask

  initial begin
    int seen;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.op = 3'd0;
    bus.src1 = 32'd0;
    bus.src2 = 32'd0;
    bus.flush = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_result", {32'd0, bus.result}, 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, "mul");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0000_0000, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, "rem");
    run_op(3'd7, 32'd100, 32'd7, 34, 32'd2, "remu");
    run_op(3'd5, 32'd1234, 32'd0, 1, 32'hFFFF_FFFF, "divu_by0");
    run_op(3'd7, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, "remu_by0");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, "rem_ovf");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");

    // flush together with in_valid in IDLE must not accept
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    bus.op = 3'd0;
    bus.src1 = 32'd3;
    bus.src2 = 32'd3;
    #1;
    check("flush_idle_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk); #1;
    check("flush_idle_no_accept", {63'd0, bus.busy}, 64'd0);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;

    // flush at T+10 of a DIVU
    issue(3'd5, 32'd100, 32'd7, "flush_divu");
    seen = 0;
    for (int k = 1; k <= 9; k++) begin
      if (bus.out_valid) seen++;
      check("flush_busy_during", {63'd0, bus.busy}, 64'd1);
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    if (bus.out_valid) seen++;
    @(posedge clk); #1;
    if (bus.out_valid) seen++;
    check("flush_no_out_valid", 64'(seen), 64'd0);
    check("flush_idle", {63'd0, bus.busy}, 64'd0);
    check("flush_result_kept", {32'd0, bus.result}, 64'h8000_0000);
    bus.flush = 1'b0;
    $display("[TB] flush_divu aborted: busy %0d result %h", bus.busy, bus.result);
    run_op(3'd5, 32'd100, 32'd7, 34, 32'd14, "after_flush_divu");

    // reset at T+20 of a MUL, with in_valid held through reset
    issue(3'd0, 32'd1000, 32'd1000, "rst_mul");
    seen = 0;
    for (int k = 1; k <= 19; k++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = 3'd0;
    bus.src1 = 32'd6;
    bus.src2 = 32'd7;
    if (bus.out_valid) seen++;
    @(posedge clk); #1;
    if (bus.out_valid) seen++;
    check("rstmid_idle", {63'd0, bus.busy}, 64'd0);
    check("rstmid_result", {32'd0, bus.result}, 64'd0);
    check("rstmid_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk); #1;
    if (bus.out_valid) seen++;
    rst = 1'b0;
    #1;
    check("rstmid_no_out_valid", 64'(seen), 64'd0);
    check("rstmid_no_accept", {63'd0, bus.busy}, 64'd0);
    check("rstmid_ready_after", {63'd0, bus.in_ready}, 64'd1);
    $display("[TB] rst_mul aborted: busy %0d result %h", bus.busy, bus.result);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_done(34, 32'd42, "mul_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: all state SHALL update on the rising edge of clk, and rst sampled high at a rising edge SHALL reset the block.
REQ-002 Port list (name, direction, width, meaning):
- clk, input, 1: clock
- rst, input, 1: synchronous active-high reset
- in_valid, input, 1: request present
- in_ready, output, 1: request accepted when in_valid & in_ready at a clk edge
- op, input, 3: operation
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- src1, input, 32: dividend / multiplicand
- src2, input, 32: divisor / multiplier
- flush, input, 1: abort any in-flight operation
- busy, output, 1: state != IDLE; drives the pipeline stall
- out_valid, output, 1: one-cycle result strobe
- result, output, 32: result, held stable until the next accept

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, CALC, FIX, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE with flush=0.
REQ-005 On accept, op, src1 and src2 SHALL be latched, and later changes on these inputs SHALL be ignored.
REQ-006 Normal path: accept at cycle T; CALC for T+1..T+32 (6-bit step counter 0..31); FIX at T+33; DONE at T+34 with out_valid=1; IDLE at T+35.
REQ-007 Multiply SHALL be radix-2 shift-add on operand magnitudes, one step per CALC cycle, into a 64-bit product.
REQ-008 The signed operands SHALL be: both operands for MULH; src1 only for MULHSU; none for MUL or MULHU.
REQ-009 In FIX, the 64-bit product SHALL be negated when exactly one signed-treated operand was negative.
REQ-010 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-011 Divide SHALL be restoring radix-2 on magnitudes (signed for DIV/REM, raw for DIVU/REMU), one quotient bit per CALC cycle, MSB first.
REQ-012 In FIX, the quotient SHALL be negated if src1 sign != src2 sign (signed ops), and the remainder SHALL take the sign of src1.
REQ-013 Divide-by-zero (src2==0, ops 4-7) SHALL skip CALC/FIX and enter DONE at T+1.
REQ-014 Divide-by-zero results SHALL be: DIV/DIVU 32'hFFFFFFFF; REM/REMU src1.
REQ-015 Signed overflow (DIV/REM with src1=32'h80000000 and src2=32'hFFFFFFFF) SHALL enter DONE at T+1 with DIV=32'h80000000 and REM=0.
REQ-016 result SHALL update only when entering DONE and SHALL otherwise hold its last value.
REQ-017 out_valid SHALL be high for exactly one cycle per completed operation.
REQ-018 busy SHALL be high in CALC, FIX and DONE, and low in IDLE.
REQ-019 flush=1 in any state SHALL force IDLE at the next edge, with no out_valid and result unchanged.
REQ-020 flush and in_valid together in IDLE SHALL give no accept.
REQ-021 flush in the DONE cycle SHALL NOT suppress that cycle's out_valid, which is already asserted.
REQ-022 in_valid SHALL be ignored in all states other than IDLE; back-to-back accepts SHALL be possible, with the next accept at earliest in the cycle after DONE.

Reset
REQ-023 rst SHALL take priority over flush and in_valid.
REQ-024 rst SHALL set state=IDLE, step counter=0, result=0, out_valid=0, busy=0 and in_ready=1 from the cycle after rst deasserts.
REQ-025 All internal product, quotient and remainder registers SHALL be cleared by rst.
REQ-026 rst asserted mid-operation SHALL abort the operation, with no out_valid.

Verification
REQ-027 The bench SHALL cover MUL: op=0, src1=7, src2=-3 -> out_valid at T+34, result=32'hFFFFFFEB; busy high T+1..T+34.
REQ-028 The bench SHALL cover MULH and MULHU with src1=src2=32'hFFFFFFFF:
- op=1 -> result=0
- op=3 -> result=32'hFFFFFFFE
REQ-029 The bench SHALL cover DIV/REM:
- op=4, src1=-7, src2=2 -> result=32'hFFFFFFFD (-3) at T+34
- op=6 with the same operands -> result=32'hFFFFFFFF (-1)
REQ-030 The bench SHALL cover special cases:
- op=5, src2=0 -> out_valid at T+1, result=32'hFFFFFFFF
- op=4, src1=32'h80000000, src2=32'hFFFFFFFF -> out_valid at T+1, result=32'h80000000
REQ-031 The bench SHALL cover flush: flush=1 at T+10 of a DIVU -> IDLE at T+11, no out_valid, result retains its prior value, and a new request accepted at T+11 completes normally.
REQ-032 The bench SHALL cover reset: rst=1 at T+20 of a MUL -> IDLE next cycle, result=0, out_valid never pulses; in_valid held throughout is accepted only after rst deasserts.
